// File: rtl/icon_pkg.sv
// ============================================================================
//  Module      : icon_pkg
//  Description : Shared constants, orientation enum and icon ROM contents for
//                the bot icon sprite generator.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package icon_pkg;

  localparam int unsigned ICON_SIZE      = 16;
  localparam int unsigned ICON_ADDR_W    = 11;
  localparam int unsigned ROW_SCALE      = 6;
  localparam int unsigned COL_SCALE_LOG2 = 3;

  typedef enum logic [2:0] {
    ORIENT_N  = 3'd0,
    ORIENT_NE = 3'd1,
    ORIENT_E  = 3'd2,
    ORIENT_SE = 3'd3,
    ORIENT_S  = 3'd4,
    ORIENT_SW = 3'd5,
    ORIENT_W  = 3'd6,
    ORIENT_NW = 3'd7
  } orient_e;

  localparam logic [1:0] ICON_TRANSPARENT = 2'b00;
  localparam logic [1:0] ICON_C1          = 2'b01;
  localparam logic [1:0] ICON_C2          = 2'b10;
  localparam logic [1:0] ICON_C3          = 2'b11;

  // Icon artwork: colour index ((orient + dy + dx) mod 3) + 1, never transparent.
  function automatic logic [1:0] icon_rom_data(input logic [ICON_ADDR_W-1:0] addr);
    logic [5:0] sum;
    logic [5:0] rem;
    sum = {3'b000, addr[10:8]} + {2'b00, addr[7:4]} + {2'b00, addr[3:0]};
    rem = sum % 6'd3;
    return rem[1:0] + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bot_icon_gen_if.sv
// ============================================================================
//  Module      : bot_icon_gen_if
//  Description : Video timing / bot state inputs and icon pixel output bundle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bot_icon_gen_if;
  logic        video_on;
  logic        vsync;
  logic [10:0] pixel_row;
  logic [10:0] pixel_column;
  logic [7:0]  loc_x;
  logic [7:0]  loc_y;
  logic [7:0]  bot_info;
  logic        blink;
  logic [1:0]  icon_px;

  modport master (
    output video_on, vsync, pixel_row, pixel_column, loc_x, loc_y, bot_info, blink,
    input  icon_px
  );

  modport slave (
    input  video_on, vsync, pixel_row, pixel_column, loc_x, loc_y, bot_info, blink,
    output icon_px
  );
endinterface

`default_nettype wire

// File: rtl/icon_rom.sv
// ============================================================================
//  Module      : icon_rom
//  Description : 2048x2 synchronous icon ROM, one-cycle read latency.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module icon_rom
  import icon_pkg::*;
(
  input  logic                   clk_i,
  input  logic [ICON_ADDR_W-1:0] addr_i,
  output logic [1:0]             data_o
);

  logic [1:0] data_q;

  always_ff @(posedge clk_i) begin
    data_q <= icon_rom_data(addr_i);
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/bot_icon_gen.sv
// ============================================================================
//  Module      : bot_icon_gen
//  Description : Robot icon sprite generator, two-cycle pixel pipeline with
//                frame-synchronised bot position. Optional ICON_BLINK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bot_icon_gen
  import icon_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  bot_icon_gen_if.slave  bus
);

  logic       vsync_q;
  logic [6:0] sh_x_q;
  logic [6:0] sh_y_q;
  orient_e    sh_orient_q;
  logic       hit_q;
  logic [1:0] icon_px_q;
  logic [1:0] icon_px_d;
  logic [1:0] rom_data;

  logic                   vs_rise;
  logic [10:0]            col_o;
  logic [10:0]            row_o;
  logic [10:0]            dx_full;
  logic [10:0]            dy_full;
  logic                   hit_d;
  logic [ICON_ADDR_W-1:0] addr_d;

  assign vs_rise = bus.vsync & ~vsync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vsync_q     <= 1'b0;
      sh_x_q      <= 7'd0;
      sh_y_q      <= 7'd0;
      sh_orient_q <= ORIENT_N;
    end else begin
      vsync_q <= bus.vsync;
      if (vs_rise) begin
        sh_x_q      <= bus.loc_x[6:0];
        sh_y_q      <= bus.loc_y[6:0];
        sh_orient_q <= orient_e'(bus.bot_info[2:0]);
      end
    end
  end

  // row origin = y*6 built from shifts; both origins stay within 11 bits
  always_comb begin
    col_o   = {1'b0, sh_x_q, 3'b000};
    row_o   = {2'b00, sh_y_q, 2'b00} + {3'b000, sh_y_q, 1'b0};
    dx_full = bus.pixel_column - col_o;
    dy_full = bus.pixel_row - row_o;
    hit_d   = bus.video_on
            && (bus.pixel_column >= col_o) && (bus.pixel_column <= col_o + 11'd15)
            && (bus.pixel_row >= row_o)    && (bus.pixel_row <= row_o + 11'd15);
    addr_d  = {sh_orient_q, dy_full[3:0], dx_full[3:0]};
  end

  icon_rom u_rom (
    .clk_i  (clk_i),
    .addr_i (addr_d),
    .data_o (rom_data)
  );

`ifdef ICON_BLINK_EN
  logic [5:0] frame_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_q <= 6'd0;
    end else if (vs_rise) begin
      frame_cnt_q <= frame_cnt_q + 6'd1;
    end
  end

  always_comb begin
    icon_px_d = hit_q ? rom_data : ICON_TRANSPARENT;
    if (bus.blink && frame_cnt_q[5]) begin
      icon_px_d = ICON_TRANSPARENT;
    end
  end

  logic w_unused_bits;
  assign w_unused_bits = ^{bus.loc_x[7], bus.loc_y[7], bus.bot_info[7:3]};
`else
  always_comb begin
    icon_px_d = hit_q ? rom_data : ICON_TRANSPARENT;
  end

  logic w_unused_bits;
  assign w_unused_bits = ^{bus.loc_x[7], bus.loc_y[7], bus.bot_info[7:3], bus.blink};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_q     <= 1'b0;
      icon_px_q <= ICON_TRANSPARENT;
    end else begin
      hit_q     <= hit_d;
      icon_px_q <= icon_px_d;
    end
  end

  assign bus.icon_px = icon_px_q;

endmodule

`default_nettype wire
